// File: rtl/llr_scaler_if.sv
// Valid/ready message bus carrying LANES packed LLR messages into and out of llr_scaler.
// The master side is the upstream producer / downstream consumer pair; the slave side is the scaler.
interface llr_scaler_if #(
  parameter int W     = 9,
  parameter int LANES = 4
);
  logic               i_valid;
  logic               o_ready;
  logic [2:0]         i_mode;
  logic [LANES*W-1:0] i_data;
  logic               o_valid;
  logic               i_ready;
  logic [LANES*W-1:0] o_data;
  logic [15:0]        o_sat_cnt;

  modport master (
    output i_valid, i_mode, i_data, i_ready,
    input  o_ready, o_valid, o_data, o_sat_cnt
  );

  modport slave (
    input  i_valid, i_mode, i_data, i_ready,
    output o_ready, o_valid, o_data, o_sat_cnt
  );
endinterface

// File: rtl/llr_scaler.sv
// Two-stage valid/ready LLR scaler: each lane is multiplied by N/8 (N selected per beat by i_mode),
// either as floored shift-add terms or as an exact rounded product, with optional symmetric clamp.
module llr_scaler #(
  parameter int W       = 9,
  parameter int LANES   = 4,
  parameter int ARITH   = 0,
  parameter int SYM_SAT = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  llr_scaler_if.slave bus
);
  localparam int PW = W + 4;
  localparam logic signed [PW-1:0] MIN_VAL = {{(PW-W+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic [W-1:0]         SAT_VAL = {1'b1, {(W-2){1'b0}}, 1'b1};
  localparam logic signed [PW-1:0] RND     = 4;

  function automatic logic signed [PW-1:0] ext(input logic signed [W-1:0] v);
    return {{(PW-W){v[W-1]}}, v};
  endfunction

  logic                 en;
  logic                 s1_valid;
  logic [3:0]           n_dec;
  logic signed [W-1:0]  lane_in  [LANES];
  logic signed [PW-1:0] res      [LANES];
  logic [W-1:0]         lane_out [LANES];
  logic [16:0]          clamp_cnt;
  logic [16:0]          cnt_sum;
  logic                 o_valid_q;
  logic [LANES*W-1:0]   o_data_q;
  logic [15:0]          sat_cnt_q;

  // Both stages advance together unless a valid output is being held by the consumer.
  assign en            = !o_valid_q || bus.i_ready;
  assign bus.o_ready   = en;
  assign bus.o_valid   = o_valid_q;
  assign bus.o_data    = o_data_q;
  assign bus.o_sat_cnt = sat_cnt_q;

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      lane_in[k] = bus.i_data[k*W +: W];
    end
  end

  // Reserved modes fall back to 0.75 so a stray mode never produces an unscaled message.
  always_comb begin
    case (bus.i_mode)
      3'd0:    n_dec = 4'd8;
      3'd1:    n_dec = 4'd7;
      3'd3:    n_dec = 4'd5;
      3'd4:    n_dec = 4'd4;
      default: n_dec = 4'd6;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
    end else if (en) begin
      s1_valid <= bus.i_valid;
    end
  end

  if (ARITH == 0) begin : g_shift
    logic [3:0]          s1_n;
    logic signed [W-1:0] s1_x [LANES];
    logic signed [W-1:0] s1_h [LANES];
    logic signed [W-1:0] s1_q [LANES];
    logic signed [W-1:0] s1_e [LANES];

    always_ff @(posedge i_clk) begin
      if (en && bus.i_valid) begin
        s1_n <= n_dec;
        for (int k = 0; k < LANES; k++) begin
          s1_x[k] <= lane_in[k];
          s1_h[k] <= lane_in[k] >>> 1;
          s1_q[k] <= lane_in[k] >>> 2;
          s1_e[k] <= lane_in[k] >>> 3;
        end
      end
    end

    always_comb begin
      for (int k = 0; k < LANES; k++) begin
        case (s1_n)
          4'd8:    res[k] = ext(s1_x[k]);
          4'd7:    res[k] = ext(s1_h[k]) + ext(s1_q[k]) + ext(s1_e[k]);
          4'd6:    res[k] = ext(s1_h[k]) + ext(s1_q[k]);
          4'd5:    res[k] = ext(s1_h[k]) + ext(s1_e[k]);
          default: res[k] = ext(s1_h[k]);
        endcase
      end
    end
  end else begin : g_mult
    logic signed [PW-1:0] s1_p [LANES];

    always_ff @(posedge i_clk) begin
      if (en && bus.i_valid) begin
        for (int k = 0; k < LANES; k++) begin
          s1_p[k] <= ext(lane_in[k]) * $signed({{(PW-4){1'b0}}, n_dec});
        end
      end
    end

    always_comb begin
      for (int k = 0; k < LANES; k++) begin
        res[k] = (s1_p[k] + RND) >>> 3;
      end
    end
  end

  // Only the most negative code can occur outside the symmetric range, so it is the sole clamp case.
  always_comb begin
    clamp_cnt = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_out[k] = res[k][W-1:0];
      if (SYM_SAT != 0 && res[k] == MIN_VAL) begin
        lane_out[k] = SAT_VAL;
        clamp_cnt   = clamp_cnt + 17'd1;
      end
    end
    cnt_sum = {1'b0, sat_cnt_q} + clamp_cnt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      sat_cnt_q <= '0;
    end else if (en) begin
      o_valid_q <= s1_valid;
      if (s1_valid) begin
        for (int k = 0; k < LANES; k++) begin
          o_data_q[k*W +: W] <= lane_out[k];
        end
        sat_cnt_q <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
      end
    end
  end
endmodule

// File: tb/tb_llr_scaler.sv
// Drives identical traffic into a shift-add (ARITH=0) and a rounded-product (ARITH=1) llr_scaler
// and checks both against hand-derived vectors and an arithmetic reference model.
module tb_llr_scaler;
  localparam int W     = 9;
  localparam int LANES = 4;
  localparam int DW    = LANES * W;

  logic i_clk = 1'b0;
  logic i_rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 i_clk = ~i_clk;

  llr_scaler_if #(.W(W), .LANES(LANES)) bus0 ();
  llr_scaler_if #(.W(W), .LANES(LANES)) bus1 ();

  llr_scaler #(.W(W), .LANES(LANES), .ARITH(0), .SYM_SAT(1)) u_dut0 (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus0.slave)
  );

  llr_scaler #(.W(W), .LANES(LANES), .ARITH(1), .SYM_SAT(1)) u_dut1 (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus1.slave)
  );

  function automatic logic [DW-1:0] pack(input int a, input int b, input int c, input int d);
    logic [W-1:0] la, lb, lc, ld;
    la = W'(a); lb = W'(b); lc = W'(c); ld = W'(d);
    return {ld, lc, lb, la};
  endfunction

  function automatic int floor_div(input int a, input int d);
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  // Reference scaling from the arithmetic definition: floor division by powers of two, then clamp.
  function automatic int ref_lane(input int x, input int mode, input int arith);
    int n, r;
    case (mode)
      0: n = 8;
      1: n = 7;
      3: n = 5;
      4: n = 4;
      default: n = 6;
    endcase
    if (arith == 0) begin
      case (n)
        8: r = x;
        7: r = floor_div(x, 2) + floor_div(x, 4) + floor_div(x, 8);
        6: r = floor_div(x, 2) + floor_div(x, 4);
        5: r = floor_div(x, 2) + floor_div(x, 8);
        default: r = floor_div(x, 2);
      endcase
    end else begin
      r = floor_div(x * n + 4, 8);
    end
    if (r == -(1 << (W - 1))) r = -((1 << (W - 1)) - 1);
    return r;
  endfunction

  function automatic logic [DW-1:0] ref_beat(input logic [DW-1:0] d, input int mode, input int arith);
    logic [DW-1:0] o;
    int x;
    o = '0;
    for (int k = 0; k < LANES; k++) begin
      x = int'($signed(d[k*W +: W]));
      o[k*W +: W] = W'(ref_lane(x, mode, arith));
    end
    return o;
  endfunction

  task automatic drive(input logic v, input int mode, input logic [DW-1:0] d, input logic rdy);
    bus0.i_valid = v;        bus1.i_valid = v;
    bus0.i_mode  = 3'(mode); bus1.i_mode  = 3'(mode);
    bus0.i_data  = d;        bus1.i_data  = d;
    bus0.i_ready = rdy;      bus1.i_ready = rdy;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Presents one beat for a single edge, then idles; returns once the beat should be on the output.
  task automatic send_beat(input logic [DW-1:0] d, input int mode);
    drive(1'b1, mode, d, 1'b1);
    tick();
    drive(1'b0, 0, '0, 1'b1);
    tick();
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    drive(1'b1, 3, pack(50, -50, 7, 9), 1'b0);
    repeat (3) tick();
    drive(1'b0, 0, '0, 1'b0);
    i_rst = 1'b0;
    n_tests++; if (bus0.o_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid0: got %b expected 0", bus0.o_valid); end
    n_tests++; if (bus1.o_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid1: got %b expected 0", bus1.o_valid); end
    n_tests++; if (bus0.o_data !== '0) begin n_fail++; $display("[TB] FAIL reset_data0: got %h expected 0", bus0.o_data); end
    n_tests++; if (bus1.o_data !== '0) begin n_fail++; $display("[TB] FAIL reset_data1: got %h expected 0", bus1.o_data); end
    n_tests++; if (bus0.o_sat_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_sat0: got %0d expected 0", bus0.o_sat_cnt); end
    n_tests++; if (bus0.o_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready0: got %b expected 1", bus0.o_ready); end
    n_tests++; if (bus1.o_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready1: got %b expected 1", bus1.o_ready); end
  endtask

  task automatic test_mode_075();
    drive(1'b1, 2, pack(100, -100, 3, -1), 1'b1);
    tick();
    drive(1'b0, 0, '0, 1'b1);
    n_tests++; if (bus0.o_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL latency_early: got %b expected 0", bus0.o_valid); end
    tick();
    n_tests++; if (bus0.o_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL latency_valid: got %b expected 1", bus0.o_valid); end
    n_tests++; if (bus0.o_data !== pack(75, -75, 1, -2)) begin n_fail++; $display("[TB] FAIL m2_shift: got %h expected %h", bus0.o_data, pack(75, -75, 1, -2)); end
    n_tests++; if (bus1.o_data !== pack(75, -75, 2, -1)) begin n_fail++; $display("[TB] FAIL m2_round: got %h expected %h", bus1.o_data, pack(75, -75, 2, -1)); end
    tick();
    n_tests++; if (bus0.o_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL single_beat_drop: got %b expected 0", bus0.o_valid); end
  endtask

  task automatic test_mode_0875();
    send_beat(pack(-256, 255, 8, -8), 1);
    n_tests++; if (bus0.o_data !== pack(-224, 221, 7, -7)) begin n_fail++; $display("[TB] FAIL m1_shift: got %h expected %h", bus0.o_data, pack(-224, 221, 7, -7)); end
    n_tests++; if (bus1.o_data !== pack(-224, 223, 7, -7)) begin n_fail++; $display("[TB] FAIL m1_round: got %h expected %h", bus1.o_data, pack(-224, 223, 7, -7)); end
    tick();
  endtask

  task automatic test_reserved_mode();
    send_beat(pack(100, -100, 0, 64), 7);
    n_tests++; if (bus0.o_data !== pack(75, -75, 0, 48)) begin n_fail++; $display("[TB] FAIL m7_shift: got %h expected %h", bus0.o_data, pack(75, -75, 0, 48)); end
    n_tests++; if (bus1.o_data !== pack(75, -75, 0, 48)) begin n_fail++; $display("[TB] FAIL m7_round: got %h expected %h", bus1.o_data, pack(75, -75, 0, 48)); end
    tick();
  endtask

  task automatic test_sym_sat();
    send_beat(pack(-256, -256, 0, 255), 0);
    n_tests++; if (bus0.o_data !== pack(-255, -255, 0, 255)) begin n_fail++; $display("[TB] FAIL sat_data0: got %h expected %h", bus0.o_data, pack(-255, -255, 0, 255)); end
    n_tests++; if (bus1.o_data !== pack(-255, -255, 0, 255)) begin n_fail++; $display("[TB] FAIL sat_data1: got %h expected %h", bus1.o_data, pack(-255, -255, 0, 255)); end
    n_tests++; if (bus0.o_sat_cnt !== 16'd2) begin n_fail++; $display("[TB] FAIL sat_cnt0: got %0d expected 2", bus0.o_sat_cnt); end
    n_tests++; if (bus1.o_sat_cnt !== 16'd2) begin n_fail++; $display("[TB] FAIL sat_cnt1: got %0d expected 2", bus1.o_sat_cnt); end
    tick();
  endtask

  task automatic test_sat_sticky();
    int exp_cnt;
    exp_cnt = 2;
    drive(1'b1, 0, pack(-256, -256, 0, 255), 1'b1);
    repeat (1000) tick();
    drive(1'b0, 0, '0, 1'b1);
    repeat (3) tick();
    exp_cnt = exp_cnt + 2 * 1000;
    n_tests++; if (bus0.o_sat_cnt !== 16'(exp_cnt)) begin n_fail++; $display("[TB] FAIL sat_partial: got %0d expected %0d", bus0.o_sat_cnt, exp_cnt); end
    drive(1'b1, 0, pack(-256, -256, 0, 255), 1'b1);
    repeat (31768) tick();
    drive(1'b0, 0, '0, 1'b1);
    repeat (3) tick();
    exp_cnt = exp_cnt + 2 * 31768;
    if (exp_cnt > 65535) exp_cnt = 65535;
    n_tests++; if (bus0.o_sat_cnt !== 16'(exp_cnt)) begin n_fail++; $display("[TB] FAIL sat_full0: got %h expected %h", bus0.o_sat_cnt, exp_cnt); end
    n_tests++; if (bus1.o_sat_cnt !== 16'(exp_cnt)) begin n_fail++; $display("[TB] FAIL sat_full1: got %h expected %h", bus1.o_sat_cnt, exp_cnt); end
    drive(1'b1, 0, pack(-256, -256, -256, -256), 1'b1);
    repeat (10) tick();
    drive(1'b0, 0, '0, 1'b1);
    repeat (3) tick();
    n_tests++; if (bus0.o_sat_cnt !== 16'hFFFF) begin n_fail++; $display("[TB] FAIL sat_hold: got %h expected ffff", bus0.o_sat_cnt); end
  endtask

  task automatic test_back_pressure();
    logic [DW-1:0] q_exp0[$];
    logic [DW-1:0] q_exp1[$];
    logic [DW-1:0] beat_data, held0, held1, exp0, exp1;
    int            beat_mode, sent, got, cyc, last_gen;
    logic          rdy, stall_prev, fire_in, fire_out;
    sent = 0; got = 0; cyc = 0; last_gen = -1; stall_prev = 1'b0;
    beat_data = '0; beat_mode = 0; held0 = '0; held1 = '0;
    while (got < 20 && cyc < 400) begin
      if (sent != last_gen && sent < 20) begin
        beat_data = pack(-200 + sent * 19, -sent * 7, sent * 20 - 190, sent);
        beat_mode = int'($urandom_range(0, 7));
        last_gen  = sent;
      end
      rdy = (cyc >= 6 && cyc < 11) ? 1'b0 : ($urandom_range(0, 2) != 0);
      drive(sent < 20, beat_mode, beat_data, rdy);
      @(negedge i_clk);
      if (stall_prev) begin
        n_tests++; if (bus0.o_valid !== 1'b1 || bus0.o_data !== held0) begin n_fail++; $display("[TB] FAIL stall_hold0: got %b/%h expected 1/%h", bus0.o_valid, bus0.o_data, held0); end
        n_tests++; if (bus1.o_valid !== 1'b1 || bus1.o_data !== held1) begin n_fail++; $display("[TB] FAIL stall_hold1: got %b/%h expected 1/%h", bus1.o_valid, bus1.o_data, held1); end
      end
      fire_in  = bus0.i_valid && bus0.o_ready;
      fire_out = bus0.o_valid && bus0.i_ready;
      if (fire_out) begin
        n_tests++;
        if (q_exp0.size() == 0) begin
          n_fail++; $display("[TB] FAIL bp_extra_beat: got %h expected no beat", bus0.o_data);
        end else begin
          exp0 = q_exp0.pop_front();
          exp1 = q_exp1.pop_front();
          if (bus0.o_data !== exp0) begin n_fail++; $display("[TB] FAIL bp_data0 beat %0d: got %h expected %h", got, bus0.o_data, exp0); end
          n_tests++;
          if (bus1.o_data !== exp1) begin n_fail++; $display("[TB] FAIL bp_data1 beat %0d: got %h expected %h", got, bus1.o_data, exp1); end
        end
        got++;
      end
      stall_prev = bus0.o_valid && !bus0.i_ready;
      held0 = bus0.o_data;
      held1 = bus1.o_data;
      if (fire_in) begin
        q_exp0.push_back(ref_beat(beat_data, beat_mode, 0));
        q_exp1.push_back(ref_beat(beat_data, beat_mode, 1));
        sent++;
      end
      @(posedge i_clk);
      #1;
      cyc++;
    end
    drive(1'b0, 0, '0, 1'b1);
    n_tests++; if (got != 20) begin n_fail++; $display("[TB] FAIL bp_count: got %0d beats expected 20", got); end
    n_tests++; if (q_exp0.size() != 0) begin n_fail++; $display("[TB] FAIL bp_leftover: got %0d pending expected 0", q_exp0.size()); end
    repeat (3) tick();
  endtask

  task automatic test_reset_midstream();
    logic seen;
    seen = 1'b0;
    drive(1'b1, 2, pack(40, 41, 42, 43), 1'b0);
    tick();
    drive(1'b1, 2, pack(50, 51, 52, 53), 1'b0);
    tick();
    n_tests++; if (bus0.o_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_inflight: got %b expected 1", bus0.o_valid); end
    i_rst = 1'b1;
    drive(1'b1, 2, pack(60, 61, 62, 63), 1'b0);
    tick();
    i_rst = 1'b0;
    drive(1'b0, 0, '0, 1'b1);
    n_tests++; if (bus0.o_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_valid0: got %b expected 0", bus0.o_valid); end
    n_tests++; if (bus1.o_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_valid1: got %b expected 0", bus1.o_valid); end
    n_tests++; if (bus0.o_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_ready: got %b expected 1", bus0.o_ready); end
    n_tests++; if (bus0.o_sat_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL mid_sat: got %0d expected 0", bus0.o_sat_cnt); end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus0.o_valid !== 1'b0 || bus1.o_valid !== 1'b0) seen = 1'b1;
    end
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_ghost: got %b expected 0", seen); end
  endtask

  initial begin
    i_rst = 1'b1;
    drive(1'b0, 0, '0, 1'b1);
    test_reset();
    test_mode_075();
    test_mode_0875();
    test_reserved_mode();
    test_sym_sat();
    test_sat_sticky();
    test_back_pressure();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
